// File: rtl/vram_blit_engine_if.sv
// Command and VRAM user-port bundle for the blit engine.
// The master side is the host plus the VRAM user port. The slave side is the engine.
interface vram_blit_engine_if #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
);

  // Host command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src;
  logic [LEN_W-1:0]  cmd_len;
  logic [7:0]        cmd_fill;
  logic              abort;

  // Status back to the host
  logic              busy;
  logic              done;
  logic              err;

  // VRAM user port (synchronous read, one cycle of latency)
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_we;
  logic [7:0]        vram_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_len, cmd_fill, abort,
    output vram_rdata,
    input  cmd_ready, busy, done, err,
    input  vram_addr, vram_wdata, vram_we
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_len, cmd_fill, abort,
    input  vram_rdata,
    output cmd_ready, busy, done, err,
    output vram_addr, vram_wdata, vram_we
  );

endinterface

// File: rtl/vram_blit_engine.sv
// VRAM fill/copy engine on the user port.
// The host issues a single FILL or COPY command. The engine then writes VRAM autonomously.
// Copies move one byte every three cycles (read, capture, write). Because each read follows
// the previous write, overlapping ranges behave as a strict forward byte-by-byte copy.
module vram_blit_engine #(
  parameter int VRAM_SIZE = 24576,
  parameter int ADDR_W    = 15,
  parameter int LEN_W     = 16
) (
  input logic              clk,
  input logic              rst,
  vram_blit_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CP_RD,
    CP_CAP,
    CP_WR,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_SIZE - 1);
  localparam logic [ADDR_W-1:0] SIZE_ADDR = ADDR_W'(VRAM_SIZE);

  state_t            state;
  logic [LEN_W-1:0]  rem;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Next address inside the VRAM window: the last byte rolls over to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // Fold a host-supplied start address into the VRAM window.
  function automatic logic [ADDR_W-1:0] addr_mod(input logic [ADDR_W-1:0] a);
    return (SIZE_ADDR != '0 && a >= SIZE_ADDR) ? a - SIZE_ADDR : a;
  endfunction

  assign bus.cmd_ready  = (state == IDLE) && !rst;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.vram_we    = we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // Command sequencer: the state and every registered output are updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          we_q   <= 1'b0;
          busy_q <= 1'b0;
          if (bus.cmd_valid) begin
            rem <= bus.cmd_len;
            if (bus.cmd_op[1]) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (bus.cmd_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (!bus.cmd_op[0]) begin
              state   <= FILL;
              busy_q  <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= addr_mod(bus.cmd_dst);
              wdata_q <= bus.cmd_fill;
              dst_ptr <= addr_inc(addr_mod(bus.cmd_dst));
            end else begin
              state   <= CP_RD;
              busy_q  <= 1'b1;
              addr_q  <= addr_mod(bus.cmd_src);
              src_ptr <= addr_inc(addr_mod(bus.cmd_src));
              dst_ptr <= addr_mod(bus.cmd_dst);
            end
          end
        end

        FILL: begin
          if (bus.abort || rem == LEN_W'(1)) begin
            state  <= DONE;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= bus.abort;
          end else begin
            rem     <= rem - LEN_W'(1);
            addr_q  <= dst_ptr;
            dst_ptr <= addr_inc(dst_ptr);
          end
        end

        CP_RD: begin
          if (bus.abort) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state <= CP_CAP;
          end
        end

        CP_CAP: begin
          if (bus.abort) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state   <= CP_WR;
            wdata_q <= bus.vram_rdata;
            addr_q  <= dst_ptr;
            dst_ptr <= addr_inc(dst_ptr);
            we_q    <= 1'b1;
          end
        end

        CP_WR: begin
          we_q <= 1'b0;
          if (bus.abort || rem == LEN_W'(1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= bus.abort;
          end else begin
            state   <= CP_RD;
            rem     <= rem - LEN_W'(1);
            addr_q  <= src_ptr;
            src_ptr <= addr_inc(src_ptr);
          end
        end

        DONE: begin
          state  <= IDLE;
          we_q   <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          we_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_blit_engine.sv
// Randomised and directed bench for vram_blit_engine.
// A command-level model produces the expected cycle trace and the expected VRAM image.
// A single compare process checks the DUT against that trace on every negative clock edge.
module tb_vram_blit_engine;

  localparam int S = 24576;

  typedef struct {
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        we;
    logic        chk_addr;
    logic [14:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vram_blit_engine_if #(.ADDR_W(15), .LEN_W(16)) bus ();

  vram_blit_engine #(.VRAM_SIZE(S), .ADDR_W(15), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:S-1];
  logic [7:0] ref_mem [0:S-1];
  exp_t       exp_q[$];
  exp_t       e;

  int   checks = 0;
  int   errors = 0;
  int   trace_idx;
  int   wr_cnt;
  int   done_idx;
  int   done_seen;
  logic last_err;

  // VRAM user port: synchronous byte RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.vram_we && int'(bus.vram_addr) < S) mem[bus.vram_addr] <= bus.vram_wdata;
    if (int'(bus.vram_addr) < S) bus.vram_rdata <= mem[bus.vram_addr];
    else bus.vram_rdata <= 8'h00;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mkExp(input logic ready, busy, done, err, we, chk,
                                 input int addr, input int wdata);
    exp_t x;
    x.ready = ready; x.busy = busy; x.done = done; x.err = err;
    x.we = we; x.chk_addr = chk; x.addr = 15'(addr); x.wdata = 8'(wdata);
    return x;
  endfunction

  function automatic int workCycles(input int op, input int len);
    if (op >= 2 || len == 0) return 0;
    return (op == 0) ? len : 3 * len;
  endfunction

  // Expected trace from the accept cycle (index 0) to the first idle cycle after completion.
  task automatic buildTrace(input int op, dst, src, len, fill, abort_k, rst_k, output int w);
    int   stop;
    bit   aborted, resetted;
    int   i, ph, a;
    logic [7:0] b;
    w = workCycles(op, len);
    stop = w; aborted = 0; resetted = 0;
    if (rst_k >= 1 && rst_k <= w) begin stop = rst_k; resetted = 1; end
    else if (abort_k >= 1 && abort_k <= w) begin stop = abort_k; aborted = 1; end
    exp_q.push_back(mkExp(1, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= stop; c++) begin
      if (op == 0) begin
        a = (dst + c - 1) % S;
        ref_mem[a] = 8'(fill);
        exp_q.push_back(mkExp(0, 1, 0, 0, 1, 1, a, fill));
      end else begin
        i = (c - 1) / 3; ph = (c - 1) % 3;
        if (ph == 0) exp_q.push_back(mkExp(0, 1, 0, 0, 0, 1, (src + i) % S, 0));
        else if (ph == 1) exp_q.push_back(mkExp(0, 1, 0, 0, 0, 0, 0, 0));
        else begin
          b = ref_mem[(src + i) % S];
          ref_mem[(dst + i) % S] = b;
          exp_q.push_back(mkExp(0, 1, 0, 0, 1, 1, (dst + i) % S, int'(b)));
        end
      end
    end
    if (!resetted) exp_q.push_back(mkExp(0, 0, 1, (op >= 2) || aborted, 0, 0, 0, 0));
    exp_q.push_back(mkExp(1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Compare process: one trace entry per cycle while a command is being traced.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput($sformatf("c%0d_ready", trace_idx), 32'(bus.cmd_ready), 32'(e.ready));
      checkOutput($sformatf("c%0d_busy", trace_idx), 32'(bus.busy), 32'(e.busy));
      checkOutput($sformatf("c%0d_done", trace_idx), 32'(bus.done), 32'(e.done));
      checkOutput($sformatf("c%0d_err", trace_idx), 32'(bus.err), 32'(e.err));
      checkOutput($sformatf("c%0d_we", trace_idx), 32'(bus.vram_we), 32'(e.we));
      if (e.chk_addr)
        checkOutput($sformatf("c%0d_addr", trace_idx), 32'(bus.vram_addr), 32'(e.addr));
      if (e.we)
        checkOutput($sformatf("c%0d_wdata", trace_idx), 32'(bus.vram_wdata), 32'(e.wdata));
      if (bus.vram_we === 1'b1) wr_cnt++;
      if (bus.done === 1'b1) begin
        done_seen++;
        done_idx = trace_idx;
        last_err = bus.err;
      end
      trace_idx++;
    end
  end

  // Drives one command starting in the current cycle, follows its trace, then checks the VRAM image.
  task automatic applyStimulus(input int op, dst, src, len, fill, abort_k, rst_k, hold);
    int w, total, mism;
    trace_idx = 0; wr_cnt = 0; done_idx = -1; done_seen = 0; last_err = 1'bx;
    buildTrace(op, dst, src, len, fill, abort_k, rst_k, w);
    total = exp_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_dst   = 15'(dst);
    bus.cmd_src   = 15'(src);
    bus.cmd_len   = 16'(len);
    bus.cmd_fill  = 8'(fill);
    bus.abort     = (abort_k == 0);
    rst           = 1'b0;
    for (int c = 1; c < total; c++) begin
      @(posedge clk); #1;
      bus.cmd_valid = (hold != 0) && (c <= w);
      if (bus.cmd_valid) begin
        bus.cmd_op   = 2'($urandom_range(0, 3));
        bus.cmd_dst  = 15'($urandom_range(0, S - 1));
        bus.cmd_src  = 15'($urandom_range(0, S - 1));
        bus.cmd_len  = 16'($urandom_range(0, 65535));
        bus.cmd_fill = 8'($urandom_range(0, 255));
      end
      bus.abort = (c == abort_k);
      rst       = (c == rst_k);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    rst           = 1'b0;
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checkOutput("trace_drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    mism = 0;
    for (int k = 0; k < S; k++) if (mem[k] !== ref_mem[k]) mism++;
    checkOutput("vram_image", 32'(mism), 32'd0);
  endtask

  initial begin
    int w;
    for (int k = 0; k < S; k++) begin
      mem[k] = 8'($urandom_range(0, 255));
      ref_mem[k] = mem[k];
    end
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_dst = '0; bus.cmd_src = '0;
    bus.cmd_len = '0; bus.cmd_fill = '0; bus.abort = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_we", 32'(bus.vram_we), 32'd0);
    checkOutput("rst_addr", 32'(bus.vram_addr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.vram_wdata), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic fill
    applyStimulus(0, 'h100, 0, 4, 'hA5, -1, -1, 0);
    checkOutput("fill_done_cycle", 32'(done_idx), 32'd5);
    checkOutput("fill_writes", 32'(wr_cnt), 32'd4);
    checkOutput("fill_byte_103", 32'(mem['h103]), 32'hA5);

    // Basic copy
    mem['h10] = 8'h11; mem['h11] = 8'h22; mem['h12] = 8'h33;
    ref_mem['h10] = 8'h11; ref_mem['h11] = 8'h22; ref_mem['h12] = 8'h33;
    applyStimulus(1, 'h200, 'h10, 3, 0, -1, -1, 0);
    checkOutput("copy_done_cycle", 32'(done_idx), 32'd10);
    checkOutput("copy_writes", 32'(wr_cnt), 32'd3);
    checkOutput("copy_byte_200", 32'(mem['h200]), 32'h11);
    checkOutput("copy_byte_202", 32'(mem['h202]), 32'h33);

    // Fill across the top of VRAM
    applyStimulus(0, 24574, 0, 4, 'h5C, -1, -1, 0);
    checkOutput("wrap_byte_24575", 32'(mem[24575]), 32'h5C);
    checkOutput("wrap_byte_0", 32'(mem[0]), 32'h5C);
    checkOutput("wrap_byte_1", 32'(mem[1]), 32'h5C);

    // Overlapping forward copy replicates the first source byte
    mem['h40] = 8'h7E; ref_mem['h40] = 8'h7E;
    applyStimulus(1, 'h41, 'h40, 3, 0, -1, -1, 0);
    checkOutput("ovl_byte_41", 32'(mem['h41]), 32'h7E);
    checkOutput("ovl_byte_43", 32'(mem['h43]), 32'h7E);

    // Illegal op, illegal op with zero length, zero-length fill
    applyStimulus(3, 'h300, 0, 5, 0, -1, -1, 0);
    checkOutput("illegal_done_cycle", 32'(done_idx), 32'd1);
    checkOutput("illegal_err", 32'(last_err), 32'd1);
    checkOutput("illegal_writes", 32'(wr_cnt), 32'd0);
    applyStimulus(2, 'h300, 0, 0, 0, -1, -1, 0);
    checkOutput("illegal_len0_err", 32'(last_err), 32'd1);
    applyStimulus(0, 'h300, 0, 0, 'h12, -1, -1, 0);
    checkOutput("len0_done_cycle", 32'(done_idx), 32'd1);
    checkOutput("len0_err", 32'(last_err), 32'd0);

    // Abort and reset in the middle of a long fill
    applyStimulus(0, 'h1000, 0, 100, 'h3C, 10, -1, 0);
    checkOutput("abort_writes", 32'(wr_cnt), 32'd10);
    checkOutput("abort_done_cycle", 32'(done_idx), 32'd11);
    checkOutput("abort_err", 32'(last_err), 32'd1);
    applyStimulus(0, 'h2000, 0, 100, 'hC3, -1, 10, 0);
    checkOutput("rst_mid_writes", 32'(wr_cnt), 32'd10);
    checkOutput("rst_mid_done_pulses", 32'(done_seen), 32'd0);

    // Request held while busy with changing fields, and abort raised in the accept cycle
    applyStimulus(1, 'h500, 'h4FE, 5, 0, 0, -1, 1);
    checkOutput("hold_writes", 32'(wr_cnt), 32'd5);

    // Random commands
    for (int n = 0; n < 40; n++) begin
      int r, op, len, ak, hold, dst, src, fill;
      r = $urandom_range(0, 7);
      if (r < 3) begin op = 0; len = $urandom_range(1, 40); end
      else if (r < 6) begin op = 1; len = $urandom_range(1, 16); end
      else if (r == 6) begin op = $urandom_range(2, 3); len = $urandom_range(0, 8); end
      else begin op = $urandom_range(0, 1); len = 0; end
      dst  = $urandom_range(0, S - 1);
      src  = (r < 6 && $urandom_range(0, 3) == 0) ? (dst + S - 1) % S : $urandom_range(0, S - 1);
      fill = $urandom_range(0, 255);
      ak = -1; hold = 0;
      w = workCycles(op, len);
      if ($urandom_range(0, 3) == 0) ak = $urandom_range(0, w + 1);
      else if ($urandom_range(0, 4) == 0) hold = 1;
      applyStimulus(op, dst, src, len, fill, ak, -1, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_blit_engine.md
Name: vram_blit_engine

Overview:
- Command-driven fill/copy engine that drives the VRAM user port (addr, data_in, we, data_out) ahead of the display mode multiplexer.
- The host issues a single command: FILL or COPY of N bytes. The engine then performs the VRAM writes autonomously while scan-out continues on the render port.
- Runs in the user clock domain. The VRAM user_clk is driven from the same clk.

Parameters:
VRAM_SIZE, 24576, number of addressable VRAM bytes; all generated addresses wrap modulo VRAM_SIZE
ADDR_W, 15, VRAM address width
LEN_W, 16, command length width

Ports:
clk  in  1  user-domain clock; also drives VRAM user_clk
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine can accept a command
cmd_op  in  2  0=FILL, 1=COPY, 2/3=illegal
cmd_dst  in  ADDR_W  destination start address
cmd_src  in  ADDR_W  source start address (COPY only)
cmd_len  in  LEN_W  byte count; 0 = no-op
cmd_fill  in  8  fill byte (FILL only)
abort  in  1  stop the current command
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  qualifies done: illegal op or aborted
vram_addr  out  ADDR_W  to VRAM user_addr
vram_wdata  out  8  to VRAM user_data_in
vram_we  out  1  to VRAM user_we
vram_rdata  in  8  from VRAM user_data_out; 1-cycle synchronous read latency

Behaviour:
- Reset values: state=IDLE; vram_we=0; vram_addr=0; vram_wdata=0; busy=0; done=0; err=0. cmd_ready is held at 0 while rst=1.
- cmd_ready = (state==IDLE) && !rst. A command is accepted when cmd_valid && cmd_ready are both high at the clk edge. All cmd_* fields are latched on acceptance.
- All vram_* outputs, busy, done and err are registered.
- States: IDLE, FILL, CP_RD, CP_CAP, CP_WR, DONE.
- Transitions from IDLE on accept:
  - op=0 and len>0 → FILL
  - op=1 and len>0 → CP_RD
  - len=0 → DONE with err=0
  - op=2/3 → DONE with err=1
  - Illegal op takes precedence over len=0.
- Cycle numbering: the accept cycle is cycle 0. busy=1 from cycle 1 until the cycle before DONE.
- FILL:
  - In cycles 1..N: vram_we=1, vram_addr=(dst+i) mod VRAM_SIZE, vram_wdata=fill, for i=0..N-1.
  - Exactly N write cycles, no gaps.
  - DONE in cycle N+1.
- COPY, per byte i, 3 cycles:
  - CP_RD (cycle 3i+1): vram_addr=src+i, vram_we=0.
  - CP_CAP (cycle 3i+2): vram_rdata is valid and is latched; vram_we=0.
  - CP_WR (cycle 3i+3): vram_addr=dst+i, vram_wdata=latched byte, vram_we=1.
  - DONE in cycle 3N+1.
  - Overlapping ranges follow exact forward byte-by-byte semantics, because every read happens after the previous write. Example: dst=src+1 replicates byte src across the range.
- Address wrap: src+i and dst+i wrap modulo VRAM_SIZE. Address 24575 is followed by 0, not 24576.
- Remaining-length counter is LEN_W bits. Decrement and termination occur on the last write, not on the last read.
- DONE state, exactly one cycle:
  - done=1, busy=0, vram_we=0, cmd_ready=0.
  - The next cycle is IDLE with cmd_ready=1.
- abort:
  - Sampled in FILL/CP_*. When sampled high at the edge ending cycle k, cycle k+1 is DONE with err=1 and no further writes.
  - A write issued in cycle k itself still completes.
  - abort is ignored in IDLE and DONE.
- cmd_valid while busy: not accepted (cmd_ready=0). The host must hold its request; no state is affected.
- rst mid-operation: the next cycle is IDLE with vram_we=0. No done pulse is generated. A partially written range is left as-is.
- Outside FILL/CP_WR, vram_we is always 0.

Test Plan:
- FILL dst=0x0100, len=4, fill=0xA5 → vram_we high cycles 1-4 at addrs 0x100-0x103, data 0xA5; done=1, err=0 in cycle 5; cmd_ready=1 in cycle 6.
- COPY src=0x0010, dst=0x0200, len=3, VRAM[0x10..0x12]=11,22,33 → writes 11,22,33 to 0x200-0x202 in cycles 3, 6, 9; done in cycle 10.
- FILL dst=24574, len=4 → writes at 24574, 24575, 0, 1; address 24576 never appears.
- Overlap COPY src=0x40, dst=0x41, len=3, VRAM[0x40]=0x7E → VRAM[0x41..0x43]=0x7E.
- Illegal op=3 with len=5 → no vram_we; done=1, err=1 in cycle 1. len=0 FILL → done=1, err=0 in cycle 1.
- FILL len=100 with abort in cycle 10 → writes in cycles 1-10 only; done=1, err=1 in cycle 11. Repeat with rst in cycle 10 → vram_we=0 from cycle 11, no done pulse, cmd_ready=1 after rst drops.
